fetch_stage: RTL and testbench

Instruction-fetch stage of the brisc pipeline. It owns the PC, issues one instruction-cache request at a time, and holds the returned word in a one-entry output slot. The IF/ID register and decode read that slot; decode takes its opcode, funct3 and funct7 fields from if_instr. Branch and jump resolution from execute redirects the PC, and the stage discards any in-flight stale fetch.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one icache request in flight,
// and parks the returned word in a one-entry slot read by decode.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ic_req_valid,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_req_ready,
  input  logic            ic_resp_valid,
  input  logic [31:0]     ic_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_next,
  output logic            if_xcpt
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic            halt_after;
  logic            slot_free;
  logic            handshake;
  logic            misaligned;
  logic            pending;

  assign slot_free    = !if_valid || id_ready;
  assign ic_req_valid = !reset && (state == S_REQ) && slot_free && !redirect_valid;
  assign ic_req_addr  = pc;
  assign handshake    = ic_req_valid && ic_req_ready;
  assign misaligned   = |redirect_pc[1:0];
  // a request still outstanding past this cycle must have its response dropped
  assign pending      = (state == S_WAIT) && !ic_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      halt_after <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
      if_xcpt    <= 1'b0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if (!misaligned) begin
        pc         <= redirect_pc;
        halt_after <= 1'b0;
        if (pending) begin
          drop <= 1'b1;
        end else begin
          drop  <= 1'b0;
          state <= S_REQ;
        end
      end else begin
        if_valid   <= 1'b1;
        if_xcpt    <= 1'b1;
        if_instr   <= NOP_INSTR;
        if_pc      <= redirect_pc;
        if_pc_next <= redirect_pc + XLEN'(4);
        if (pending) begin
          drop       <= 1'b1;
          halt_after <= 1'b1;
        end else begin
          drop       <= 1'b0;
          halt_after <= 1'b0;
          state      <= S_HALT;
        end
      end
    end else begin
      if (if_valid && id_ready) if_valid <= 1'b0;
      case (state)
        S_REQ: if (handshake) state <= S_WAIT;
        S_WAIT: begin
          if (ic_resp_valid) begin
            if (drop) begin
              drop       <= 1'b0;
              halt_after <= 1'b0;
              state      <= halt_after ? S_HALT : S_REQ;
            end else begin
              // slot is empty here: the request was only issued with slot_free
              if_valid   <= 1'b1;
              if_xcpt    <= 1'b0;
              if_instr   <= ic_resp_data;
              if_pc      <= pc;
              if_pc_next <= pc + XLEN'(4);
              pc         <= pc + XLEN'(4);
              state      <= S_REQ;
            end
          end
        end
        S_HALT: ;
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a request-tracking reference model plus a
// small icache model with variable latency.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [31:0] ic_req_addr, ic_resp_data;
  logic        redirect_valid, id_ready;
  logic [31:0] redirect_pc;
  logic        if_valid, if_xcpt;
  logic [31:0] if_instr, if_pc, if_pc_next;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .if_xcpt(if_xcpt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  // reference model: next fetch address, one tracked request with a stale tag, halt flag
  logic [31:0] m_pc, s_i, s_p;
  bit          m_halted, m_inflight, m_stale, s_v, s_x;
  // icache model
  bit          pend_v, stray, last_hs;
  int          pend_cnt, lat_fix;
  logic [31:0] pend_addr;

  task automatic model_reset();
    m_pc = RST_PC; m_halted = 0; m_inflight = 0; m_stale = 0;
    s_v = 0; s_x = 0; s_i = '0; s_p = '0;
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic cycle(input bit rdy, input bit idr, input bit rv, input logic [31:0] rpc);
    bit resp, exp_req, hs;
    logic [31:0] rdata;
    ic_req_ready = rdy; id_ready = idr; redirect_valid = rv; redirect_pc = rpc;
    resp = 0; rdata = $urandom;
    if (stray) begin
      resp = 1; stray = 0;
    end else if (pend_v) begin
      if (pend_cnt <= 1) begin resp = 1; pend_v = 0; rdata = mem(pend_addr); end
      else pend_cnt--;
    end
    ic_resp_valid = resp; ic_resp_data = rdata;
    @(negedge clk);
    exp_req = !m_halted && !m_inflight && (!s_v || idr) && !rv;
    check("req_valid", ic_req_valid, exp_req);
    if (exp_req) check("req_addr", ic_req_addr, m_pc);
    check("if_valid", if_valid, s_v);
    if (s_v) begin
      check("if_instr", if_instr, s_i);
      check("if_pc", if_pc, s_p);
      check("if_pc_next", if_pc_next, s_p + 32'd4);
      check("if_xcpt", if_xcpt, s_x);
    end
    last_hs = ic_req_valid && rdy;
    if (last_hs) begin
      pend_v = 1; pend_addr = ic_req_addr;
      pend_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
    hs = exp_req && rdy;
    if (rv) begin
      s_v = 0;
      if (m_inflight) begin
        if (resp) begin m_inflight = 0; m_stale = 0; end
        else m_stale = 1;
      end
      if (rpc[1:0] == 2'b00) begin
        m_pc = rpc; m_halted = 0;
      end else begin
        m_halted = 1; s_v = 1; s_x = 1; s_i = NOP; s_p = rpc;
      end
    end else begin
      if (s_v && idr) s_v = 0;
      if (resp && m_inflight) begin
        m_inflight = 0;
        if (m_stale) m_stale = 0;
        else begin s_v = 1; s_x = 0; s_i = mem(m_pc); s_p = m_pc; m_pc = m_pc + 32'd4; end
      end
      if (hs) m_inflight = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_to_handshake();
    last_hs = 0;
    for (int i = 0; i < 20 && !last_hs; i++) cycle(1, 1, 0, '0);
    check("reach_hs", last_hs, 1);
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1; ic_req_ready = 0; ic_resp_valid = 0; ic_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; id_ready = 0;
    pend_v = 0; stray = 0; lat_fix = 1; last_hs = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_valid", ic_req_valid, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_pc_next", if_pc_next, 0);
    check("rst_if_xcpt", if_xcpt, 0);
    reset = 0;

    // streaming with a 1-cycle icache
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
    // decode stall
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, '0);
    // redirect while waiting; the stale word arrives 3 cycles later
    lat_fix = 4;
    run_to_handshake();
    cycle(1, 1, 1, 32'h2000);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
    // redirect coincident with the response
    lat_fix = 2;
    run_to_handshake();
    cycle(1, 1, 0, '0);
    cycle(1, 1, 1, 32'h3000);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);
    // misaligned redirect halts fetch until a good redirect
    lat_fix = 1;
    cycle(1, 0, 1, 32'h2002);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, '0);
    cycle(1, 1, 1, 32'h4000);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);
    // PC wrap
    cycle(1, 1, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
    // reset while waiting, then a stray late response
    lat_fix = 5;
    run_to_handshake();
    cycle(1, 1, 0, '0);
    reset = 1; redirect_valid = 0; ic_resp_valid = 0;
    #2;
    check("midrst_req_valid", ic_req_valid, 0);
    check("midrst_if_valid", if_valid, 0);
    check("midrst_if_pc", if_pc, 0);
    model_reset(); pend_v = 0;
    @(posedge clk); #1;
    reset = 0; stray = 1; lat_fix = 1;
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);

    // random traffic
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rpc[31:8] = 24'hFF_FFFF;
      cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 8, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
